// File: rtl/flappy_bird_physics.sv
// Flappy-bird game logic: IDLE/PLAY/DEAD state machine, gravity integration,
// flap and collision handling. Visible state changes only on frame_tick or state transitions.
`timescale 1ns/1ps
module flappy_bird_physics #(
    parameter int BIRD_X      = 140,
    parameter int START_Y     = 240,
    parameter int BIRD_H      = 20,
    parameter int GROUND_Y    = 440,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = -8,
    parameter int MAX_FALL    = 10,
    parameter int DEAD_FRAMES = 60
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       frame_tick,
    input  logic       btn_flap,
    input  logic       pipe_hit,
    output logic [9:0] bird_x,
    output logic [9:0] bird_y,
    output logic [1:0] game_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_DEAD = 2'b10;

    localparam logic signed [7:0]  C_GRAV   = 8'(GRAVITY);
    localparam logic signed [7:0]  C_FLAP   = 8'(FLAP_VEL);
    localparam logic signed [7:0]  C_MAXF   = 8'(MAX_FALL);
    localparam logic signed [11:0] C_BIRD_H = 12'(BIRD_H);
    localparam logic signed [11:0] C_GROUND = 12'(GROUND_Y);
    localparam logic [9:0]         C_START  = 10'(START_Y);
    localparam logic [9:0]         C_REST_Y = 10'(GROUND_Y - BIRD_H);
    localparam logic [5:0]         C_DEAD_N = 6'(DEAD_FRAMES);

    logic              sync1, sync2, sync3;
    logic              flap_edge;
    logic              flap_pend, hit_pend;
    logic signed [7:0] vel;
    logic [5:0]        dead_cnt;

    logic [1:0]         st_d;
    logic [9:0]         y_d;
    logic signed [7:0]  vel_d;
    logic [5:0]         cnt_d;
    logic               fp_d, hp_d;
    logic               flap_now, hit_now;
    logic signed [7:0]  vel_inc, vel_grav, vel_n;
    logic signed [11:0] y_n;
    logic               above_top, on_ground;
    logic [9:0]         y_c;
    logic signed [7:0]  v_c;

    assign bird_x    = 10'(BIRD_X);
    assign flap_edge = sync2 & ~sync3;

    // Events arriving in the same cycle as frame_tick count for that tick.
    assign flap_now  = flap_pend | flap_edge;
    assign hit_now   = hit_pend | pipe_hit;

    always_comb begin
        vel_inc   = vel + C_GRAV;
        vel_grav  = (vel_inc > C_MAXF) ? C_MAXF : vel_inc;
        vel_n     = flap_now ? C_FLAP : vel_grav;
        y_n       = $signed({2'b00, bird_y}) + {{4{vel_n[7]}}, vel_n};
        above_top = y_n[11];
        on_ground = !above_top && (y_n + C_BIRD_H >= C_GROUND);
        y_c       = above_top ? 10'd0 : y_n[9:0];
        v_c       = above_top ? 8'sd0 : vel_n;
    end

    always_comb begin
        st_d  = game_state;
        y_d   = bird_y;
        vel_d = vel;
        cnt_d = dead_cnt;
        fp_d  = flap_pend | flap_edge;
        hp_d  = hit_pend | (pipe_hit && game_state == ST_PLAY);
        if (frame_tick) begin
            fp_d = 1'b0;
            hp_d = 1'b0;
        end
        case (game_state)
            ST_IDLE: begin
                y_d   = C_START;
                vel_d = 8'sd0;
                hp_d  = 1'b0;
                if (flap_edge) begin
                    st_d = ST_PLAY;
                    fp_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (on_ground) begin
                        y_d   = C_REST_Y;
                        vel_d = 8'sd0;
                        st_d  = ST_DEAD;
                    end else begin
                        y_d   = y_c;
                        vel_d = v_c;
                        if (hit_now) st_d = ST_DEAD;
                    end
                    if (st_d == ST_DEAD) cnt_d = 6'd0;
                end
            end
            ST_DEAD: begin
                hp_d = 1'b0;
                if (frame_tick && dead_cnt < C_DEAD_N) cnt_d = dead_cnt + 6'd1;
                if (flap_edge && dead_cnt == C_DEAD_N) begin
                    st_d  = ST_IDLE;
                    y_d   = C_START;
                    vel_d = 8'sd0;
                    cnt_d = 6'd0;
                    fp_d  = 1'b0;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        if (st_d != game_state && !(game_state == ST_IDLE && st_d == ST_PLAY)) fp_d = 1'b0;
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            bird_y     <= C_START;
            vel        <= 8'sd0;
            game_state <= ST_IDLE;
            flap_pend  <= 1'b0;
            hit_pend   <= 1'b0;
            dead_cnt   <= 6'd0;
        end else begin
            sync1      <= btn_flap;
            sync2      <= sync1;
            sync3      <= sync2;
            bird_y     <= y_d;
            vel        <= vel_d;
            game_state <= st_d;
            flap_pend  <= fp_d;
            hit_pend   <= hp_d;
            dead_cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_flappy_bird_physics.sv
// Self-checking bench for flappy_bird_physics: table-driven arc, scoreboarded
// frame ticks, and hand-written sequences for ground, top clamp, hit, holdoff and reset.
`timescale 1ns/1ps
module tb_flappy_bird_physics;

    logic       dclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_flap = 1'b0;
    logic       pipe_hit = 1'b0;
    logic [9:0] bird_x, bird_y;
    logic [1:0] game_state;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_DEAD = 2'b10;

    flappy_bird_physics dut (
        .dclk(dclk), .clr_n(clr_n), .frame_tick(frame_tick), .btn_flap(btn_flap),
        .pipe_hit(pipe_hit), .bird_x(bird_x), .bird_y(bird_y), .game_state(game_state)
    );

    always #20 dclk = ~dclk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, state=%0d y=%0d", game_state, bird_y);
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        bit         flap;
        bit         hit;
        logic [9:0] y;
        logic [1:0] st;
    } vec_t;
    vec_t arc_tab[4];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got state=%0d y=%0d, expected state=%0d y=%0d",
                     name, act[11:10], act[9:0], expv[11:10], expv[9:0]);
        end
    endtask

    task automatic check_x(input string name);
        n_checks++;
        if (bird_x !== 10'd140) begin
            n_fail++;
            $display("FAIL %s: bird_x got %0d expected 140", name, bird_x);
        end
    endtask

    // One frame tick; expected {state, y} is queued when stimulus is driven.
    task automatic do_tick(input string name, input bit coinc_flap, input bit hit_mid,
                           input logic [1:0] st, input logic [9:0] y);
        logic [11:0] e;
        exp_q.push_back({st, y});
        if (hit_mid) begin
            @(negedge dclk) pipe_hit = 1'b1;
            @(negedge dclk) pipe_hit = 1'b0;
        end
        if (coinc_flap) begin
            @(negedge dclk) btn_flap = 1'b1;
            @(negedge dclk);
            @(negedge dclk) frame_tick = 1'b1;
        end else begin
            @(negedge dclk) frame_tick = 1'b1;
        end
        @(negedge dclk);
        frame_tick = 1'b0;
        btn_flap   = 1'b0;
        e = exp_q.pop_front();
        check(name, {game_state, bird_y}, e);
        repeat (4) @(negedge dclk);
        check({name, "_hold"}, {game_state, bird_y}, e);
    endtask

    task automatic flap_to(input string name, input logic [1:0] want, input int budget);
        bit found = 1'b0;
        @(negedge dclk) btn_flap = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge dclk);
            #1;
            if (game_state == want) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: state got %0d expected %0d within %0d dclk", name, game_state, want, budget);
        end
        @(negedge dclk) btn_flap = 1'b0;
        repeat (3) @(negedge dclk);
    endtask

    task automatic flap_ignored(input string name, input logic [9:0] y);
        @(negedge dclk) btn_flap = 1'b1;
        repeat (6) @(negedge dclk);
        btn_flap = 1'b0;
        repeat (3) @(negedge dclk);
        check(name, {game_state, bird_y}, {S_DEAD, y});
    endtask

    initial begin
        int y;
        int v;
        bit hit_ground;

        arc_tab[0] = '{flap: 1'b0, hit: 1'b0, y: 10'd232, st: S_PLAY};
        arc_tab[1] = '{flap: 1'b0, hit: 1'b0, y: 10'd225, st: S_PLAY};
        arc_tab[2] = '{flap: 1'b0, hit: 1'b0, y: 10'd219, st: S_PLAY};
        arc_tab[3] = '{flap: 1'b0, hit: 1'b0, y: 10'd214, st: S_PLAY};

        // Reset and idle ticks
        repeat (5) @(posedge dclk);
        @(negedge dclk) clr_n = 1'b1;
        check_x("reset_x");
        check("reset", {game_state, bird_y}, {S_IDLE, 10'd240});
        for (int i = 0; i < 10; i++) do_tick("idle_tick", 1'b0, 1'b0, S_IDLE, 10'd240);
        do_tick("idle_hit", 1'b0, 1'b1, S_IDLE, 10'd240);

        // Start and arc
        flap_to("start_play", S_PLAY, 4);
        for (int i = 0; i < 4; i++)
            do_tick("arc", arc_tab[i].flap, arc_tab[i].hit, arc_tab[i].st, arc_tab[i].y);

        // Free fall to terminal velocity and ground
        y = 214;
        v = -5;
        hit_ground = 1'b0;
        for (int i = 0; i < 100 && !hit_ground; i++) begin
            v = (v + 1 > 10) ? 10 : v + 1;
            if (y + v + 20 >= 440) begin
                hit_ground = 1'b1;
                do_tick("ground", 1'b0, 1'b0, S_DEAD, 10'd420);
            end else begin
                y = y + v;
                do_tick("fall", 1'b0, 1'b0, S_PLAY, 10'(y));
            end
        end
        check_x("dead_x");

        // Dead holdoff: 30 ticks ignored, 59 ignored, 60 accepted
        for (int i = 0; i < 30; i++) do_tick("dead_tick", 1'b0, (i == 3), S_DEAD, 10'd420);
        flap_ignored("holdoff_30", 10'd420);
        for (int i = 0; i < 29; i++) do_tick("dead_tick", 1'b0, 1'b0, S_DEAD, 10'd420);
        flap_ignored("holdoff_59", 10'd420);
        do_tick("dead_tick60", 1'b0, 1'b0, S_DEAD, 10'd420);
        flap_to("dead_to_idle", S_IDLE, 4);
        check("idle_y", {game_state, bird_y}, {S_IDLE, 10'd240});

        // Pipe hit mid-frame, then hit while dead
        flap_to("start_play2", S_PLAY, 4);
        do_tick("hit_pre", 1'b0, 1'b0, S_PLAY, 10'd232);
        do_tick("hit", 1'b0, 1'b1, S_DEAD, 10'd225);
        for (int i = 0; i < 60; i++) do_tick("dead2", 1'b0, (i == 0), S_DEAD, 10'd225);
        flap_to("dead2_to_idle", S_IDLE, 4);

        // Top clamp with flaps coincident with frame_tick
        flap_to("start_play3", S_PLAY, 4);
        do_tick("climb0", 1'b0, 1'b0, S_PLAY, 10'd232);
        for (int k = 1; k <= 29; k++) do_tick("climb", 1'b1, 1'b0, S_PLAY, 10'(232 - 8 * k));
        do_tick("top_clamp", 1'b1, 1'b0, S_PLAY, 10'd0);
        do_tick("after_clamp", 1'b0, 1'b0, S_PLAY, 10'd1);
        do_tick("after_clamp2", 1'b0, 1'b0, S_PLAY, 10'd3);

        // Asynchronous reset pulse away from any dclk edge
        @(posedge dclk);
        #10 clr_n = 1'b0;
        #0.5;
        check("async_reset", {game_state, bird_y}, {S_IDLE, 10'd240});
        check_x("async_reset_x");
        #0.5 clr_n = 1'b1;
        do_tick("post_reset", 1'b0, 1'b0, S_IDLE, 10'd240);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
